// File: rtl/div_pkg.sv
// Shared types and constants for the divider job sequencer.
package div_pkg;

    // Operand / quotient width the divider bus is built for.
    localparam int DEF_WIDTH = 5;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        LOAD_A = 2'd2,
        WAIT   = 2'd3
    } seq_state_t;

    // Quotient reported for a divide-by-zero job.
    localparam logic [DEF_WIDTH-1:0] QUOT_DBZ = {DEF_WIDTH{1'b1}};

endpackage

// File: rtl/div_job_fifo.sv
// Small synchronous job FIFO with occupancy count; a full FIFO never accepts,
// even when a pop happens in the same cycle.
module div_job_fifo #(
    parameter  int DW    = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_s;
    logic          pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;

    // Next occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Storage, pointers (wrapping modulo DEPTH) and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/div_job_sequencer.sv
// Feeds queued dividend/divisor jobs to the serial repeated-subtraction
// divider, screens divide-by-zero, aborts hung jobs and returns quotients.
module div_job_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             div_start,
    output logic [WIDTH-1:0] div_data,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic             out_dbz,
    output logic             out_timeout,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] QUOT_ALL_ONES = {WIDTH{1'b1}};

    logic [2*WIDTH-1:0] fifo_wdata_s;
    logic [2*WIDTH-1:0] fifo_rdata_s;
    logic [CW-1:0]      fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic [WIDTH-1:0]   head_dividend_s;
    logic [WIDTH-1:0]   head_divisor_s;

    seq_state_t         state_q;
    logic [TW-1:0]      timer_q;
    logic [WIDTH-1:0]   job_dividend_q;
    logic               div_start_q;
    logic [WIDTH-1:0]   div_data_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_quotient_q;
    logic               out_dbz_q;
    logic               out_timeout_q;

    assign fifo_wdata_s    = {in_dividend, in_divisor};
    assign head_dividend_s = fifo_rdata_s[2*WIDTH-1:WIDTH];
    assign head_divisor_s  = fifo_rdata_s[WIDTH-1:0];

    // in_ready is decoded from the registered count only.
    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && !fifo_full_s;
    // Only pop when idle and the result slot is free (one bubble per result).
    assign pop_s    = (state_q == IDLE) && !fifo_empty_s && !out_valid_q;

    div_job_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Sequencer FSM with timer, job register and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            job_dividend_q <= '0;
            div_start_q    <= 1'b0;
            div_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_quotient_q <= '0;
            out_dbz_q      <= 1'b0;
            out_timeout_q  <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    div_start_q <= 1'b0;
                    if (pop_s) begin
                        job_dividend_q <= head_dividend_s;
                        if (head_divisor_s == '0) begin
                            out_valid_q    <= 1'b1;
                            out_quotient_q <= QUOT_ALL_ONES;
                            out_dbz_q      <= 1'b1;
                            out_timeout_q  <= 1'b0;
                        end else begin
                            state_q     <= LOAD_B;
                            div_start_q <= 1'b1;
                            div_data_q  <= head_divisor_s;
                        end
                    end
                end
                LOAD_B: begin
                    state_q     <= LOAD_A;
                    div_start_q <= 1'b1;
                    div_data_q  <= job_dividend_q;
                end
                LOAD_A: begin
                    state_q     <= WAIT;
                    div_start_q <= 1'b0;
                    timer_q     <= '0;
                end
                WAIT: begin
                    div_start_q <= 1'b0;
                    // A done seen on the first WAIT cycle may belong to the previous job.
                    if (div_done && (timer_q != '0)) begin
                        out_valid_q    <= 1'b1;
                        out_quotient_q <= div_quotient;
                        out_dbz_q      <= 1'b0;
                        out_timeout_q  <= 1'b0;
                        state_q        <= IDLE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        out_valid_q    <= 1'b1;
                        out_quotient_q <= '0;
                        out_dbz_q      <= 1'b0;
                        out_timeout_q  <= 1'b1;
                        state_q        <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    div_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_start    = div_start_q;
    assign div_data     = div_data_q;
    assign out_valid    = out_valid_q;
    assign out_quotient = out_quotient_q;
    assign out_dbz      = out_dbz_q;
    assign out_timeout  = out_timeout_q;
    assign busy         = (state_q != IDLE) || (fifo_count_s != '0);

endmodule

// File: tb/tb_div_job_sequencer.sv
// Self-checking bench for div_job_sequencer with a behavioural serial
// repeated-subtraction divider and a result scoreboard.
module tb_div_job_sequencer;

    localparam int W       = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [W-1:0] q;
        logic         dbz;
        logic         to;
    } res_t;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        res_t         exp;
        bit           started;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         div_start;
    logic [W-1:0] div_data;
    logic         div_done;
    logic [W-1:0] div_quotient;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic         out_dbz;
    logic         out_timeout;
    logic         busy;

    int   errors = 0;
    int   checks = 0;
    res_t sb_q[$];
    bit   saw_start;
    bit   hang_en;
    bit   force_stale;

    // Behavioural divider state.
    logic         m_ld_q;
    logic         m_run_q;
    logic         m_done_q;
    logic [W-1:0] m_a_q;
    logic [W-1:0] m_b_q;
    logic [W-1:0] m_q_q;

    always #5 clk = ~clk;

    div_job_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_start    (div_start),
        .div_data     (div_data),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_dbz      (out_dbz),
        .out_timeout  (out_timeout),
        .busy         (busy)
    );

    // Serial divider: divisor on the first start cycle, dividend on the second,
    // then one subtraction per cycle; done held until the next start.
    // With hang_en set, a divisor of 13 never raises done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ld_q <= 1'b0; m_run_q <= 1'b0; m_done_q <= 1'b0;
            m_a_q <= '0; m_b_q <= '0; m_q_q <= '0;
        end else if (div_start) begin
            if (!m_ld_q) begin
                m_b_q <= div_data; m_ld_q <= 1'b1; m_done_q <= 1'b0; m_run_q <= 1'b0;
            end else begin
                m_a_q <= div_data; m_q_q <= '0; m_ld_q <= 1'b0; m_run_q <= 1'b1;
            end
        end else if (m_run_q) begin
            if (m_a_q >= m_b_q) begin
                m_a_q <= m_a_q - m_b_q;
                m_q_q <= m_q_q + 5'd1;
            end else begin
                m_run_q  <= 1'b0;
                m_done_q <= !(hang_en && (m_b_q == 5'd13));
            end
        end
    end

    assign div_done     = m_done_q | force_stale;
    assign div_quotient = m_q_q;

    // Notes any divider start pulse.
    always @(negedge clk) begin
        if (div_start) saw_start = 1'b1;
    end

    // Scoreboard: compare each result at its handshake.
    always @(negedge clk) begin
        res_t got;
        res_t exp;
        if (rst_n && out_valid && out_ready) begin
            got = '{out_quotient, out_dbz, out_timeout};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got q=%0d dbz=%0b to=%0b with no job outstanding",
                         got.q, got.dbz, got.to);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sb_result: got q=%0d dbz=%0b to=%0b expected q=%0d dbz=%0b to=%0b",
                             got.q, got.dbz, got.to, exp.q, exp.dbz, exp.to);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},     32'(in_ready),     32'd1);
        check({tag, "_div_start"},    32'(div_start),    32'd0);
        check({tag, "_div_data"},     32'(div_data),     32'd0);
        check({tag, "_out_valid"},    32'(out_valid),    32'd0);
        check({tag, "_out_quotient"}, 32'(out_quotient), 32'd0);
        check({tag, "_out_dbz"},      32'(out_dbz),      32'd0);
        check({tag, "_out_timeout"},  32'(out_timeout),  32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
    endtask

    // Offer a job, waiting (bounded) until accepted; called at posedge+1.
    task automatic push_job(input logic [W-1:0] dd, input logic [W-1:0] dv, input res_t exp);
        int n;
        n = 0;
        in_dividend = dd; in_divisor = dv; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb_q.push_back(exp);
            #1 in_valid = 1'b0;
        end
    endtask

    // Offer a job for exactly one cycle; called at posedge+1.
    task automatic try_push(input logic [W-1:0] dd, input logic [W-1:0] dv, input res_t exp,
                            output bit acc);
        in_dividend = dd; in_divisor = dv; in_valid = 1'b1;
        acc = in_ready;
        @(posedge clk);
        if (acc) sb_q.push_back(exp);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && !out_valid) && n < budget) begin
            @(negedge clk); n++;
        end
        checks++;
        if (!(sb_q.size() == 0 && !out_valid)) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding after %0d cycles, required 0",
                     name, sb_q.size(), n);
        end
    endtask

    task automatic wait_load_a(input logic [W-1:0] d);
        int n;
        n = 0;
        while (!(div_start && div_data == d) && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (!(div_start && div_data == d)) begin
            errors++;
            $display("FAIL load_a_seen: div_start=%0b div_data=%0d, required 1 and %0d",
                     div_start, div_data, d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        vec_t bp[6];
        bit   acc_exp[6];
        bit   acc;
        logic [W-1:0] held_q;

        vecs[0] = '{5'd15, 5'd2,  '{5'd7,  1'b0, 1'b0}, 1'b1};
        vecs[1] = '{5'd9,  5'd0,  '{5'd31, 1'b1, 1'b0}, 1'b0};
        vecs[2] = '{5'd31, 5'd1,  '{5'd31, 1'b0, 1'b0}, 1'b1};
        vecs[3] = '{5'd0,  5'd5,  '{5'd0,  1'b0, 1'b0}, 1'b1};
        vecs[4] = '{5'd12, 5'd4,  '{5'd3,  1'b0, 1'b0}, 1'b1};
        vecs[5] = '{5'd3,  5'd7,  '{5'd0,  1'b0, 1'b0}, 1'b1};
        vecs[6] = '{5'd0,  5'd0,  '{5'd31, 1'b1, 1'b0}, 1'b0};
        vecs[7] = '{5'd31, 5'd31, '{5'd1,  1'b0, 1'b0}, 1'b1};

        bp[0] = '{5'd14, 5'd3,  '{5'd4, 1'b0, 1'b0}, 1'b1};
        bp[1] = '{5'd20, 5'd4,  '{5'd5, 1'b0, 1'b0}, 1'b1};
        bp[2] = '{5'd31, 5'd31, '{5'd1, 1'b0, 1'b0}, 1'b1};
        bp[3] = '{5'd7,  5'd9,  '{5'd0, 1'b0, 1'b0}, 1'b1};
        bp[4] = '{5'd10, 5'd5,  '{5'd2, 1'b0, 1'b0}, 1'b1};
        bp[5] = '{5'd8,  5'd2,  '{5'd4, 1'b0, 1'b0}, 1'b1};
        acc_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
        out_ready = 1'b1; hang_en = 1'b0; force_stale = 1'b0; saw_start = 1'b0;

        // Reset values.
        #12;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // 15/2: operand sequencing and latency from the push edge N.
        @(posedge clk); #1;
        in_dividend = 5'd15; in_divisor = 5'd2; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back('{5'd7, 1'b0, 1'b0});
        #1 in_valid = 1'b0;
        @(negedge clk); check("lat_n1_start", 32'(div_start), 32'd0);
        @(negedge clk); check("lat_loadb_start", 32'(div_start), 32'd1);
        check("lat_loadb_data", 32'(div_data), 32'd2);
        @(negedge clk); check("lat_loada_start", 32'(div_start), 32'd1);
        check("lat_loada_data", 32'(div_data), 32'd15);
        @(negedge clk); check("lat_wait_start", 32'(div_start), 32'd0);
        check("lat_wait_data", 32'(div_data), 32'd15);
        wait_drain("lat", 200);

        // 9/0: screened, result two cycles after the push.
        saw_start = 1'b0;
        @(posedge clk); #1;
        in_dividend = 5'd9; in_divisor = 5'd0; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back('{5'd31, 1'b1, 1'b0});
        #1 in_valid = 1'b0;
        @(negedge clk); check("dbz_n1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); check("dbz_n2_valid", 32'(out_valid), 32'd1);
        check("dbz_quot", 32'(out_quotient), 32'd31);
        check("dbz_flag", 32'(out_dbz), 32'd1);
        wait_drain("dbz", 50);
        check("dbz_no_start", 32'(saw_start), 32'd0);

        // Table of single jobs.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            saw_start = 1'b0;
            push_job(vecs[i].dd, vecs[i].dv, vecs[i].exp);
            wait_drain("vec", 300);
            check("vec_started", 32'(saw_start), 32'(vecs[i].started));
        end

        // Backpressure: fill the FIFO while the first result is held.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            try_push(bp[i].dd, bp[i].dv, bp[i].exp, acc);
            check("bp_accept", 32'(acc), 32'(acc_exp[i]));
        end
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        repeat (40) @(negedge clk);
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_quot", 32'(out_quotient), 32'd4);
        held_q = out_quotient;
        repeat (5) @(negedge clk);
        check("bp_stable_quot", 32'(out_quotient), 32'(held_q));
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_still_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("bp", 800);

        // Hung divider: timeout exactly TIMEOUT cycles into WAIT, next job normal.
        @(posedge clk); #1;
        hang_en = 1'b1;
        push_job(5'd20, 5'd13, '{5'd0, 1'b0, 1'b1});
        push_job(5'd26, 5'd6,  '{5'd4, 1'b0, 1'b0});
        wait_load_a(5'd20);
        repeat (TIMEOUT) @(negedge clk);
        check("to_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("to_valid", 32'(out_valid), 32'd1);
        check("to_flag", 32'(out_timeout), 32'd1);
        check("to_quot", 32'(out_quotient), 32'd0);
        wait_drain("to", 300);
        hang_en = 1'b0;

        // Stale done through LOAD_B/LOAD_A and the first WAIT cycle.
        @(posedge clk); #1;
        force_stale = 1'b1;
        push_job(5'd20, 5'd4, '{5'd5, 1'b0, 1'b0});
        wait_load_a(5'd20);
        @(posedge clk);
        @(posedge clk);
        #1 force_stale = 1'b0;
        wait_drain("stale", 200);

        // Reset during WAIT with three jobs queued.
        @(posedge clk); #1;
        try_push(5'd31, 5'd1, '{5'd31, 1'b0, 1'b0}, acc);
        try_push(5'd30, 5'd1, '{5'd30, 1'b0, 1'b0}, acc);
        try_push(5'd29, 5'd1, '{5'd29, 1'b0, 1'b0}, acc);
        try_push(5'd28, 5'd1, '{5'd28, 1'b0, 1'b0}, acc);
        repeat (2) @(posedge clk);
        #3;
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push_job(5'd12, 5'd4, '{5'd3, 1'b0, 1'b0});
        wait_drain("postrst", 200);
        repeat (100) @(negedge clk);
        check("postrst_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
